// File: rtl/apu_ch3_pkg.sv
// Shared types and helpers for the channel-3 wave playback path.
// Holds the volume code encoding and the nibble volume shifter.
package apu_ch3_pkg;

    localparam int POS_W  = 5;
    localparam int FREQ_W = 11;

    typedef enum logic [1:0] {
        MUTE    = 2'b00,
        FULL    = 2'b01,
        HALF    = 2'b10,
        QUARTER = 2'b11
    } vol_code_e;

    function automatic logic [3:0] shift_sample(input logic [3:0] s, input vol_code_e v);
        logic [3:0] r;
        r = '0;
        case (v)
            MUTE:    r = '0;
            FULL:    r = s;
            HALF:    r = s >> 1;
            QUARTER: r = s >> 2;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ch3_freq_timer.sv
// Channel-3 frequency timer: a half-rate up-counter that reloads from freq on
// overflow. A load (trigger) restarts both the counter and the phase.
module ch3_freq_timer #(
    parameter int FREQ_W = apu_ch3_pkg::FREQ_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              load,
    input  logic [FREQ_W-1:0] freq,
    output logic              overflow
);

    logic              phase;
    logic [FREQ_W-1:0] cnt;

    // Load takes priority, so a trigger landing on an overflow suppresses the advance.
    assign overflow = run & phase & ~load & (&cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= 1'b0;
            cnt   <= '0;
        end else begin
            phase <= load ? 1'b0 : ~phase;
            if (load || overflow)
                cnt <= freq;
            else if (run && phase)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ch3_wave_sequencer.sv
// Channel-3 playback sequencer: sample position, wave RAM fetch/latch pipeline,
// play/stop control, CPU FF3x arbitration and volume shifting toward the mixer.
module ch3_wave_sequencer #(
    parameter int POS_W  = apu_ch3_pkg::POS_W,
    parameter int FREQ_W = apu_ch3_pkg::FREQ_W
) (
    input  logic              amuk_4mhz,
    input  logic              apu_reset,
    input  logic              ch3_trigger,
    input  logic              ch3_dac_en,
    input  logic              length_expire,
    input  logic [FREQ_W-1:0] freq,
    input  logic [1:0]        vol_code,
    input  logic [POS_W-2:0]  cpu_addr,
    input  logic              cpu_wave_req,
    input  logic [7:0]        wave_byte,
    output logic [POS_W-2:0]  wave_addr,
    output logic              wave_fetch,
    output logic              nibble_sel,
    output logic              ch3_active,
    output logic              cpu_access_ok,
    output logic [3:0]        sample_out
);

    import apu_ch3_pkg::*;

    logic             trig;
    logic             ovf;
    logic             active;
    logic             fetch_d;
    logic [POS_W-1:0] pos;
    logic [7:0]       latch;
    logic [3:0]       sample_q;

    assign trig = ch3_trigger & ch3_dac_en;

    ch3_freq_timer #(.FREQ_W(FREQ_W)) u_timer (
        .clk      (amuk_4mhz),
        .rst      (apu_reset),
        .run      (active),
        .load     (trig),
        .freq     (freq),
        .overflow (ovf)
    );

    always_ff @(posedge amuk_4mhz) begin
        if (apu_reset) begin
            active     <= 1'b0;
            pos        <= '0;
            wave_fetch <= 1'b0;
            fetch_d    <= 1'b0;
            latch      <= 8'h00;
            sample_q   <= '0;
        end else begin
            if (trig)
                active <= 1'b1;
            else if (length_expire || !ch3_dac_en)
                active <= 1'b0;

            if (trig)
                pos <= '0;
            else if (ovf)
                pos <= pos + 1'b1;

            // RAM data arrives the cycle after the strobe; capture it one cycle later.
            wave_fetch <= ovf;
            fetch_d    <= wave_fetch;
            if (fetch_d)
                latch <= wave_byte;

            sample_q <= shift_sample(pos[0] ? latch[3:0] : latch[7:4], vol_code_e'(vol_code));
        end
    end

    assign nibble_sel = pos[0];
    assign ch3_active = active;
    assign sample_out = active ? sample_q : 4'h0;

    // While playing the RAM port belongs to the sequencer; the CPU only gets
    // through in the fetch cycle and the one after it.
    assign wave_addr     = active ? pos[POS_W-1:1] : cpu_addr;
    assign cpu_access_ok = cpu_wave_req & (~active | wave_fetch | fetch_d);

endmodule

// File: tb/tb_ch3_wave_sequencer.sv
// Bench for ch3_wave_sequencer: directed scenarios then randomized traffic, all
// checked each cycle against a countdown-based behavioural model of the channel.
module tb_ch3_wave_sequencer;

    logic        clk = 1'b0;
    logic        apu_reset, ch3_trigger, ch3_dac_en, length_expire, cpu_wave_req;
    logic [10:0] freq;
    logic [1:0]  vol_code;
    logic [3:0]  cpu_addr;
    logic [7:0]  wave_byte;
    logic [3:0]  wave_addr;
    logic        wave_fetch, nibble_sel, ch3_active, cpu_access_ok;
    logic [3:0]  sample_out;

    ch3_wave_sequencer dut (
        .amuk_4mhz     (clk),
        .apu_reset     (apu_reset),
        .ch3_trigger   (ch3_trigger),
        .ch3_dac_en    (ch3_dac_en),
        .length_expire (length_expire),
        .freq          (freq),
        .vol_code      (vol_code),
        .cpu_addr      (cpu_addr),
        .cpu_wave_req  (cpu_wave_req),
        .wave_byte     (wave_byte),
        .wave_addr     (wave_addr),
        .wave_fetch    (wave_fetch),
        .nibble_sel    (nibble_sel),
        .ch3_active    (ch3_active),
        .cpu_access_ok (cpu_access_ok),
        .sample_out    (sample_out)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0] ram [16];

    // Model: clocks remaining until the next sample advance, position, pipeline.
    bit         m_active, m_fetch, m_fetch_d;
    int         m_cnt, m_pos, m_sample;
    logic [7:0] m_latch;

    function automatic int vol_apply(int s, int v);
        case (v)
            1:       return s;
            2:       return s / 2;
            3:       return s / 4;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_step();
        int  nib, n_sample;
        bit  trig, adv;
        logic [7:0] n_latch;
        if (apu_reset) begin
            m_active = 0; m_fetch = 0; m_fetch_d = 0;
            m_cnt = 0; m_pos = 0; m_sample = 0; m_latch = 8'h00;
            return;
        end
        nib      = (m_pos % 2 == 1) ? int'(m_latch) % 16 : int'(m_latch) / 16;
        n_sample = vol_apply(nib, int'(vol_code));
        n_latch  = m_fetch_d ? wave_byte : m_latch;
        trig     = ch3_trigger && ch3_dac_en;
        adv      = 0;
        if (trig) begin
            m_pos = 0;
            m_cnt = (2048 - int'(freq)) * 2;
        end else if (m_active) begin
            m_cnt--;
            if (m_cnt == 0) begin
                adv   = 1;
                m_pos = (m_pos + 1) % 32;
                m_cnt = (2048 - int'(freq)) * 2;
            end
        end
        if (trig) m_active = 1;
        else if (length_expire || !ch3_dac_en) m_active = 0;
        m_fetch_d = m_fetch;
        m_fetch   = adv;
        m_latch   = n_latch;
        m_sample  = n_sample;
    endtask

    task automatic check_all();
        chk("wave_fetch", 32'(wave_fetch), 32'(m_fetch));
        chk("ch3_active", 32'(ch3_active), 32'(m_active));
        chk("nibble_sel", 32'(nibble_sel), 32'(m_pos % 2));
        chk("wave_addr", 32'(wave_addr), m_active ? 32'(m_pos / 2) : 32'(cpu_addr));
        chk("cpu_access_ok", 32'(cpu_access_ok),
            32'(cpu_wave_req && (!m_active || m_fetch || m_fetch_d)));
        chk("sample_out", 32'(sample_out), m_active ? 32'(m_sample) : 32'd0);
    endtask

    task automatic tick();
        wave_byte = m_fetch_d ? ram[m_pos / 2] : 8'($urandom);
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
        apu_reset = 1; ch3_trigger = 0; ch3_dac_en = 0; length_expire = 0;
        cpu_wave_req = 0; freq = '0; vol_code = 2'd1; cpu_addr = '0; wave_byte = '0;
        m_active = 0; m_fetch = 0; m_fetch_d = 0; m_cnt = 0; m_pos = 0; m_sample = 0;
        m_latch = 8'h00;

        // Reset state
        ticks(2);
        chk("rst_fetch", 32'(wave_fetch), 0);
        chk("rst_active", 32'(ch3_active), 0);
        chk("rst_sample", 32'(sample_out), 0);
        chk("rst_addr", 32'(wave_addr), 0);
        apu_reset = 0;
        ch3_dac_en = 1;
        cpu_addr = 4'd9;

        // 1: freq=2046, first fetch after 4 clocks, then every 4
        freq = 11'd2046; ch3_trigger = 1; tick(); ch3_trigger = 0;
        ticks(3);
        chk("t1_nofetch", 32'(wave_fetch), 0);
        tick();
        chk("t1_fetch", 32'(wave_fetch), 1);
        chk("t1_addr", 32'(wave_addr), 0);
        chk("t1_nib", 32'(nibble_sel), 1);
        ticks(4);
        chk("t1_fetch2", 32'(wave_fetch), 1);
        chk("t1_addr2", 32'(wave_addr), 1);
        chk("t1_nib2", 32'(nibble_sel), 0);

        // 4: CPU window only in fetch cycle and the next
        cpu_wave_req = 1;
        tick(); chk("t4_ok_after", 32'(cpu_access_ok), 1);
        tick(); chk("t4_ok_blk1", 32'(cpu_access_ok), 0);
        chk("t4_addr_hold", 32'(wave_addr), 1);
        tick(); chk("t4_ok_blk2", 32'(cpu_access_ok), 0);
        tick(); chk("t4_ok_fetch", 32'(cpu_access_ok), 1);
        chk("t4_addr_seq", 32'(wave_addr), 1);
        cpu_wave_req = 0;

        // 2: freq=2047, 64 clocks wrap the position
        freq = 11'd2047; ch3_trigger = 1; tick(); ch3_trigger = 0;
        ticks(62);
        chk("t2_addr15", 32'(wave_addr), 15);
        chk("t2_nib31", 32'(nibble_sel), 1);
        ticks(2);
        chk("t2_wrap_addr", 32'(wave_addr), 0);
        chk("t2_wrap_nib", 32'(nibble_sel), 0);
        chk("t2_wrap_fetch", 32'(wave_fetch), 1);

        // 3: volume shifts on 0xA5, low nibble at pos 1 then high nibble at pos 2
        ram[0] = 8'hA5; ram[1] = 8'hA5;
        freq = 11'd2040; vol_code = 2'd1; ch3_trigger = 1; tick(); ch3_trigger = 0;
        ticks(19);
        chk("t3_lo_full", 32'(sample_out), 5);
        vol_code = 2'd2; tick(); chk("t3_lo_half", 32'(sample_out), 2);
        vol_code = 2'd3; tick(); chk("t3_lo_quarter", 32'(sample_out), 1);
        vol_code = 2'd0; tick(); chk("t3_lo_mute", 32'(sample_out), 0);
        vol_code = 2'd1; ticks(13); chk("t3_hi_full", 32'(sample_out), 10);
        vol_code = 2'd2; tick(); chk("t3_hi_half", 32'(sample_out), 5);
        vol_code = 2'd3; tick(); chk("t3_hi_quarter", 32'(sample_out), 2);
        vol_code = 2'd0; tick(); chk("t3_hi_mute", 32'(sample_out), 0);
        vol_code = 2'd1;

        // 5: trigger beats length_expire; length_expire alone stops the channel
        ch3_trigger = 1; length_expire = 1; tick(); ch3_trigger = 0; length_expire = 0;
        chk("t5_active", 32'(ch3_active), 1);
        chk("t5_pos0", 32'(nibble_sel), 0);
        chk("t5_addr0", 32'(wave_addr), 0);
        ticks(20);
        length_expire = 1; tick(); length_expire = 0;
        chk("t5_stop", 32'(ch3_active), 0);
        chk("t5_sample0", 32'(sample_out), 0);
        chk("t5_cpu_addr", 32'(wave_addr), 9);
        ticks(5);
        chk("t5_nofetch", 32'(wave_fetch), 0);

        // 6: reset the cycle after a fetch aborts it and clears the latch
        ram[0] = 8'h3C; cpu_addr = 4'd0;
        freq = 11'd2047; ch3_trigger = 1; tick(); ch3_trigger = 0;
        ticks(2);
        chk("t6_fetch", 32'(wave_fetch), 1);
        apu_reset = 1; tick(); apu_reset = 0;
        chk("t6_rst_fetch", 32'(wave_fetch), 0);
        chk("t6_rst_active", 32'(ch3_active), 0);
        chk("t6_rst_addr", 32'(wave_addr), 0);
        tick();
        chk("t6_no_late_fetch", 32'(wave_fetch), 0);
        ch3_trigger = 1; tick(); ch3_trigger = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_latch_clear", 32'(sample_out), 0);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) freq = 11'(2040 + $urandom_range(0, 7));
            if ($urandom_range(0, 63) == 0) ram[$urandom_range(0, 15)] = 8'($urandom);
            ch3_trigger   = ($urandom_range(0, 40) == 0);
            length_expire = ($urandom_range(0, 150) == 0);
            ch3_dac_en    = ($urandom_range(0, 200) != 0);
            apu_reset     = ($urandom_range(0, 999) == 0);
            vol_code      = 2'($urandom_range(0, 3));
            cpu_wave_req  = 1'($urandom_range(0, 1));
            cpu_addr      = 4'($urandom_range(0, 15));
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
